// File: rtl/huff_min2_merge_if.sv
// Handshake bundle for the Huffman minimum-pair selector: node-frame input
// stream and the end-of-pass result channel.
interface huff_min2_merge_if;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] in_frame;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_min0;
    logic [35:0] out_min1;
    logic [35:0] out_parent;
    logic        out_single;
    logic        out_sat;
    logic [9:0]  out_count;

    modport slave (
        input  in_valid, in_frame, in_last, out_ready,
        output in_ready, out_valid, out_min0, out_min1, out_parent,
        output out_single, out_sat, out_count
    );

    modport master (
        output in_valid, in_frame, in_last, out_ready,
        input  in_ready, out_valid, out_min0, out_min1, out_parent,
        input  out_single, out_sat, out_count
    );
endinterface

// File: rtl/huff_min2_merge.sv
// Streaming two-smallest selector over one pass of node frames; at end of pass
// presents both minima and the merged parent frame with a persistent parent ID.
module huff_min2_merge (
    input  logic              clk,
    input  logic              rst,
    huff_min2_merge_if.slave  bus
);
    localparam logic [8:0]  PARENT_ID_BASE = 9'd256;
    localparam logic [9:0]  COUNT_MAX_M1   = 10'd511;

    typedef enum logic {SCAN = 1'b0, EMIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [9:0]  count_q, count_d;
    logic [35:0] min0_q, min0_d;
    logic [35:0] min1_q, min1_d;
    logic        min1_vld_q, min1_vld_d;
    logic [35:0] parent_q, parent_d;
    logic        single_q, single_d;
    logic        sat_q, sat_d;
    logic [8:0]  pid_q, pid_d;
    logic [27:0] sum_w;
    logic        accept;
    logic        pass_done;

    // Frame a precedes b: lower weight, then lower-or-equal ID.
    function automatic logic precedes(input logic [35:0] a, input logic [35:0] b);
        return (a[26:0] < b[26:0]) || ((a[26:0] == b[26:0]) && (a[35:27] <= b[35:27]));
    endfunction

    function automatic logic [26:0] sat_weight(input logic [27:0] s);
        return s[27] ? 27'h7FFFFFF : s[26:0];
    endfunction

    assign accept    = (state_q == SCAN) && bus.in_valid;
    assign pass_done = accept && (bus.in_last || (count_q == COUNT_MAX_M1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SCAN;
            count_q    <= '0;
            min0_q     <= '0;
            min1_q     <= '0;
            min1_vld_q <= 1'b0;
            parent_q   <= '0;
            single_q   <= 1'b0;
            sat_q      <= 1'b0;
            pid_q      <= PARENT_ID_BASE;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            min0_q     <= min0_d;
            min1_q     <= min1_d;
            min1_vld_q <= min1_vld_d;
            parent_q   <= parent_d;
            single_q   <= single_d;
            sat_q      <= sat_d;
            pid_q      <= pid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:    if (pass_done) state_d = EMIT;
            EMIT:    if (bus.out_ready) state_d = SCAN;
            default: state_d = SCAN;
        endcase
    end

    // Datapath next state; the result registers are loaded on the closing
    // handshake so every output comes straight from a flop.
    always_comb begin
        count_d    = count_q;
        min0_d     = min0_q;
        min1_d     = min1_q;
        min1_vld_d = min1_vld_q;
        parent_d   = parent_q;
        single_d   = single_q;
        sat_d      = sat_q;
        pid_d      = pid_q;
        sum_w      = '0;
        if (accept) begin
            count_d = count_q + 10'd1;
            if (count_q == 10'd0) begin
                min0_d     = bus.in_frame;
                min1_d     = '0;
                min1_vld_d = 1'b0;
            end else if (precedes(bus.in_frame, min0_q)) begin
                min1_d     = min0_q;
                min1_vld_d = 1'b1;
                min0_d     = bus.in_frame;
            end else if (!min1_vld_q || precedes(bus.in_frame, min1_q)) begin
                min1_d     = bus.in_frame;
                min1_vld_d = 1'b1;
            end
            if (pass_done) begin
                sum_w    = {1'b0, min0_d[26:0]} + {1'b0, min1_d[26:0]};
                single_d = !min1_vld_d;
                sat_d    = min1_vld_d && sum_w[27];
                parent_d = min1_vld_d ? {pid_q, sat_weight(sum_w)} : 36'd0;
            end
        end else if ((state_q == EMIT) && bus.out_ready) begin
            count_d    = '0;
            min0_d     = '0;
            min1_d     = '0;
            min1_vld_d = 1'b0;
            parent_d   = '0;
            single_d   = 1'b0;
            sat_d      = 1'b0;
            if (count_q >= 10'd2)
                pid_d = (pid_q == 9'd511) ? PARENT_ID_BASE : pid_q + 9'd1;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == SCAN);
        bus.out_valid = (state_q == EMIT);
    end

    assign bus.out_min0   = min0_q;
    assign bus.out_min1   = min1_q;
    assign bus.out_parent = parent_q;
    assign bus.out_single = single_q;
    assign bus.out_sat    = sat_q;
    assign bus.out_count  = count_q;
endmodule

// File: tb/tb_huff_min2_merge.sv
// Bench for huff_min2_merge: directed passes plus randomized passes scored
// against a sort-based reference of the two smallest frames.
module tb_huff_min2_merge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    huff_min2_merge_if bus ();

    huff_min2_merge dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [35:0] fr[$];
    logic [8:0]  exp_pid = 9'd256;
    logic [35:0] got_min0, got_min1, got_parent;
    logic        got_sat, got_single;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk(input int id, input logic [26:0] w);
        logic [8:0] i9;
        i9 = id[8:0];
        return {i9, w};
    endfunction

    // Ordering key: weight major, ID minor; smallest key is the preferred node.
    function automatic logic [35:0] key(input logic [35:0] f);
        return {f[26:0], f[35:27]};
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {35'd0, bus.in_ready}, 36'd1);
        chk({tag, "_out_valid"}, {35'd0, bus.out_valid}, 36'd0);
        chk({tag, "_min0"}, bus.out_min0, 36'd0);
        chk({tag, "_min1"}, bus.out_min1, 36'd0);
        chk({tag, "_parent"}, bus.out_parent, 36'd0);
        chk({tag, "_single"}, {35'd0, bus.out_single}, 36'd0);
        chk({tag, "_sat"}, {35'd0, bus.out_sat}, 36'd0);
        chk({tag, "_count"}, {26'd0, bus.out_count}, 36'd0);
    endtask

    task automatic do_pass(input string tag, input int gap_max, input int hold, input bit use_last);
        int          n, idx0, idx1;
        logic [35:0] e0, e1, ep;
        logic [27:0] s;
        logic        esat, esing;
        n = fr.size();
        idx0 = 0;
        for (int i = 1; i < n; i++)
            if (key(fr[i]) < key(fr[idx0])) idx0 = i;
        idx1 = -1;
        for (int i = 0; i < n; i++)
            if (i != idx0 && (idx1 < 0 || key(fr[i]) < key(fr[idx1]))) idx1 = i;
        e0 = fr[idx0];
        if (n == 1) begin
            e1 = '0; ep = '0; esat = 1'b0; esing = 1'b1;
        end else begin
            e1 = fr[idx1];
            s = {1'b0, e0[26:0]} + {1'b0, e1[26:0]};
            esat = (s > 28'h7FFFFFF);
            ep = {exp_pid, esat ? 27'h7FFFFFF : s[26:0]};
            esing = 1'b0;
        end

        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int k = 0; k < g; k++) begin
                bus.in_valid = 1'b0;
                bus.in_frame = {$urandom, $urandom};
                bus.in_last  = 1'b1;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_frame = fr[i];
            bus.in_last  = use_last && (i == n - 1);
            @(posedge clk); #1;
            if (i < n - 1) chk({tag, "_no_early_valid"}, {35'd0, bus.out_valid}, 36'd0);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        chk({tag, "_out_valid"}, {35'd0, bus.out_valid}, 36'd1);
        chk({tag, "_in_ready_low"}, {35'd0, bus.in_ready}, 36'd0);
        chk({tag, "_min0"}, bus.out_min0, e0);
        chk({tag, "_min1"}, bus.out_min1, e1);
        chk({tag, "_parent"}, bus.out_parent, ep);
        chk({tag, "_single"}, {35'd0, bus.out_single}, {35'd0, esing});
        chk({tag, "_sat"}, {35'd0, bus.out_sat}, {35'd0, esat});
        chk({tag, "_count"}, {26'd0, bus.out_count}, n);
        got_min0 = bus.out_min0; got_min1 = bus.out_min1; got_parent = bus.out_parent;
        got_sat = bus.out_sat; got_single = bus.out_single;

        for (int k = 0; k < hold; k++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_frame  = '0;
            bus.in_last   = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, {35'd0, bus.out_valid}, 36'd1);
            chk({tag, "_hold_in_ready"}, {35'd0, bus.in_ready}, 36'd0);
            chk({tag, "_hold_min0"}, bus.out_min0, e0);
            chk({tag, "_hold_parent"}, bus.out_parent, ep);
            chk({tag, "_hold_count"}, {26'd0, bus.out_count}, n);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_ready_back"}, {35'd0, bus.in_ready}, 36'd1);
        chk({tag, "_valid_drop"}, {35'd0, bus.out_valid}, 36'd0);
        chk({tag, "_count_clr"}, {26'd0, bus.out_count}, 36'd0);
        if (n >= 2) exp_pid = (exp_pid == 9'd511) ? 9'd256 : exp_pid + 9'd1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_frame  = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        fr = '{mk(3, 10), mk(5, 4), mk(1, 4), mk(7, 20)};
        do_pass("basic", 0, 0, 1'b1);
        chk("basic_min0_const", got_min0, {9'd1, 27'd4});
        chk("basic_min1_const", got_min1, {9'd5, 27'd4});
        chk("basic_parent_const", got_parent, {9'd256, 27'd8});
        do_pass("basic2", 0, 0, 1'b1);
        chk("basic2_parent_const", got_parent, {9'd257, 27'd8});

        fr = '{mk(9, 6), mk(9, 6), mk(2, 6)};
        do_pass("ties", 0, 0, 1'b1);
        chk("ties_min0_const", got_min0, {9'd2, 27'd6});
        chk("ties_min1_const", got_min1, {9'd9, 27'd6});

        fr = '{mk(300, 100)};
        do_pass("single", 0, 0, 1'b1);
        chk("single_flag_const", {35'd0, got_single}, 36'd1);
        chk("single_parent_const", got_parent, 36'd0);
        fr = '{mk(0, 1), mk(1, 1)};
        do_pass("after_single", 0, 0, 1'b1);
        chk("after_single_id", {27'd0, got_parent[35:27]}, 36'd259);

        fr = '{mk(4, 27'h7FFFFFF), mk(6, 27'h0000001)};
        do_pass("sat", 0, 0, 1'b1);
        chk("sat_flag_const", {35'd0, got_sat}, 36'd1);
        chk("sat_weight_const", {9'd0, got_parent[26:0]}, 36'h7FFFFFF);

        fr = '{mk(3, 10), mk(5, 4), mk(1, 4), mk(7, 20)};
        do_pass("backpressure", 0, 3, 1'b1);

        fr.delete();
        for (int i = 0; i < 512; i++) fr.push_back(mk($urandom_range(511, 0), 27'($urandom)));
        do_pass("count_limit", 0, 1, 1'b0);

        for (int p = 0; p < 30; p++) begin
            int n;
            bit big;
            n = $urandom_range(12, 1);
            big = ($urandom_range(3, 0) == 0);
            fr.delete();
            for (int i = 0; i < n; i++)
                fr.push_back(mk($urandom_range(15, 0),
                    big ? 27'h7FFFFF0 + 27'($urandom_range(15, 0)) : 27'($urandom_range(7, 0))));
            do_pass("random", 2, $urandom_range(2, 0), 1'b1);
        end

        bus.in_valid = 1'b1; bus.in_frame = mk(5, 3); bus.in_last = 1'b0;
        @(posedge clk); #1;
        bus.in_frame = mk(6, 2);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midpass_rst");
        rst = 1'b0;
        exp_pid = 9'd256;
        @(posedge clk); #1;
        chk("midpass_no_valid", {35'd0, bus.out_valid}, 36'd0);
        fr = '{mk(0, 1), mk(1, 1)};
        do_pass("after_rst", 0, 0, 1'b1);
        chk("after_rst_parent_const", got_parent, {9'd256, 27'd2});

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_pid = 9'd256;
        for (int k = 1; k <= 257; k++) begin
            fr = '{mk($urandom_range(511, 0), 27'($urandom_range(1000, 0))),
                   mk($urandom_range(511, 0), 27'($urandom_range(1000, 0)))};
            do_pass("wrap", 0, 0, 1'b1);
            if (k == 256) chk("wrap_id_256th", {27'd0, got_parent[35:27]}, 36'd511);
            if (k == 257) chk("wrap_id_257th", {27'd0, got_parent[35:27]}, 36'd256);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
